// File: rtl/sopc_arb_pkg.sv
// Shared types and default sizes for the two-port on-chip memory arbiter.
// Optional burst hold is enabled by defining SOPC_ARB_BURST_EN.
package sopc_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int AW_DEF        = 12;
    localparam int DW_DEF        = 32;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/sopc_arb_rr_pick.sv
// Combinational winner selection between requesters A and B.
// With SOPC_ARB_BURST_EN the owner keeps ties for up to MAX_BURST grants; otherwise ties alternate.
module sopc_arb_rr_pick
    import sopc_arb_pkg::*;
`ifdef SOPC_ARB_BURST_EN
#(
    parameter int MAX_BURST = MAX_BURST_DEF
)
`endif
(
    input  logic       a_act_i,
    input  logic       b_act_i,
    input  owner_e     owner_i,
`ifdef SOPC_ARB_BURST_EN
    input  logic [3:0] burst_cnt_i,
`endif
    output logic       grant_a_o,
    output logic       grant_b_o
);

    logic hold;
    logic tie_a;

`ifdef SOPC_ARB_BURST_EN
    // A zero count only exists straight out of reset; treating it as "no burst yet"
    // lets A take the first tie even though B is the nominal owner.
    assign hold = (burst_cnt_i != 4'd0) && (burst_cnt_i < 4'(MAX_BURST));
`else
    assign hold = 1'b0;
`endif

    assign tie_a     = (owner_i == OWN_A) ? hold : ~hold;
    assign grant_a_o = a_act_i & (~b_act_i | tie_a);
    assign grant_b_o = b_act_i & ~grant_a_o;

endmodule

// File: rtl/sopc_onchip_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM (one access per cycle).
// Define SOPC_ARB_BURST_EN to let the current owner hold ties for MAX_BURST grants.
module sopc_onchip_mem_arbiter
    import sopc_arb_pkg::*;
#(
    parameter  int AW        = AW_DEF,
    parameter  int DW        = DW_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int BEW       = DW / 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [AW-1:0]  a_address,
    input  logic [BEW-1:0] a_byteenable,
    input  logic           a_read,
    input  logic           a_write,
    input  logic [DW-1:0]  a_writedata,
    output logic           a_waitrequest,
    output logic [DW-1:0]  a_readdata,
    output logic           a_readdatavalid,
    input  logic [AW-1:0]  b_address,
    input  logic [BEW-1:0] b_byteenable,
    input  logic           b_read,
    input  logic           b_write,
    input  logic [DW-1:0]  b_writedata,
    output logic           b_waitrequest,
    output logic [DW-1:0]  b_readdata,
    output logic           b_readdatavalid,
    output logic [AW-1:0]  mem_address,
    output logic [BEW-1:0] mem_byteenable,
    output logic           mem_chipselect,
    output logic           mem_write,
    output logic [DW-1:0]  mem_writedata,
    output logic           mem_clken,
    input  logic [DW-1:0]  mem_readdata
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..15");
    end

    logic   a_act, b_act;
    logic   grant_a, grant_b;
    logic   a_acc, b_acc;
    owner_e owner_q, owner_d;
    logic   a_rdv_q, b_rdv_q;

    assign a_act = a_read | a_write;
    assign b_act = b_read | b_write;

`ifdef SOPC_ARB_BURST_EN
    logic [3:0] burst_cnt_q, burst_cnt_d;

    sopc_arb_rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .a_act_i    (a_act),
        .b_act_i    (b_act),
        .owner_i    (owner_q),
        .burst_cnt_i(burst_cnt_q),
        .grant_a_o  (grant_a),
        .grant_b_o  (grant_b)
    );

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if ((a_acc && owner_q == OWN_A) || (b_acc && owner_q == OWN_B))
            burst_cnt_d = (burst_cnt_q >= 4'(MAX_BURST)) ? 4'(MAX_BURST) : burst_cnt_q + 4'd1;
        else if (a_acc || b_acc)
            burst_cnt_d = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) burst_cnt_q <= 4'd0;
        else       burst_cnt_q <= burst_cnt_d;
    end
`else
    sopc_arb_rr_pick u_pick (
        .a_act_i  (a_act),
        .b_act_i  (b_act),
        .owner_i  (owner_q),
        .grant_a_o(grant_a),
        .grant_b_o(grant_b)
    );
`endif

    // Nothing is accepted while reset is high, so both requesters are stalled.
    assign a_waitrequest = reset | (a_act & ~grant_a);
    assign b_waitrequest = reset | (b_act & ~grant_b);
    assign a_acc         = grant_a & ~reset;
    assign b_acc         = grant_b & ~reset;

    assign mem_address    = grant_b ? b_address    : a_address;
    assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
    assign mem_writedata  = grant_b ? b_writedata  : a_writedata;
    assign mem_chipselect = a_acc | b_acc;
    assign mem_write      = (a_acc & a_write) | (b_acc & b_write);
    assign mem_clken      = 1'b1;

    always_comb begin
        owner_d = owner_q;
        if (a_acc)      owner_d = OWN_A;
        else if (b_acc) owner_d = OWN_B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_B;
            a_rdv_q <= 1'b0;
            b_rdv_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            a_rdv_q <= a_acc & ~a_write;
            b_rdv_q <= b_acc & ~b_write;
        end
    end

    // Gating with reset kills a read that was in flight when reset arrived.
    assign a_readdatavalid = a_rdv_q & ~reset;
    assign b_readdatavalid = b_rdv_q & ~reset;
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;

endmodule

// File: tb/tb_sopc_onchip_mem_arbiter.sv
// Scoreboard bench for sopc_onchip_mem_arbiter with a behavioural RAM on the mem side.
// Grant-order expectations depend on SOPC_ARB_BURST_EN.
module tb_sopc_onchip_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [11:0] a_address, b_address, mem_address;
    logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_writedata, b_writedata, mem_writedata;
    logic        a_waitrequest, b_waitrequest;
    logic [31:0] a_readdata, b_readdata, mem_readdata;
    logic        a_readdatavalid, b_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    typedef struct {
        logic        port_b;
        logic [31:0] data;
    } sb_t;

    sb_t         exp_q[$];
    logic [31:0] shadow [0:4095];
    logic [31:0] ram    [0:4095];
    logic [11:0] rd_addr_q;
    int          n_chk  = 0;
    int          n_fail = 0;

    sopc_onchip_mem_arbiter #(.AW(12), .DW(32), .MAX_BURST(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .a_address      (a_address),
        .a_byteenable   (a_byteenable),
        .a_read         (a_read),
        .a_write        (a_write),
        .a_writedata    (a_writedata),
        .a_waitrequest  (a_waitrequest),
        .a_readdata     (a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address      (b_address),
        .b_byteenable   (b_byteenable),
        .b_read         (b_read),
        .b_write        (b_write),
        .b_writedata    (b_writedata),
        .b_waitrequest  (b_waitrequest),
        .b_readdata     (b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with registered address and unregistered output.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            rd_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[rd_addr_q];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_a(input logic rd, input logic wr, input logic [11:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        a_read = rd; a_write = wr; a_address = ad; a_writedata = d; a_byteenable = be;
    endtask

    task automatic set_b(input logic rd, input logic wr, input logic [11:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        b_read = rd; b_write = wr; b_address = ad; b_writedata = d; b_byteenable = be;
    endtask

    task automatic accept(input logic port_b, input logic wr, input logic [11:0] ad,
                          input logic [31:0] d, input logic [3:0] be);
        sb_t e;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) shadow[ad][8*i +: 8] = d[8*i +: 8];
        end else begin
            e.port_b = port_b;
            e.data   = shadow[ad];
            exp_q.push_back(e);
        end
    endtask

    // One bus cycle: check stalls, mem strobes and the scoreboard, then advance.
    task automatic cyc(input logic exp_wa, input logic exp_wb);
        sb_t  e;
        logic pa, pb;
        @(negedge clk);
        pa = !reset && (a_read || a_write) && !exp_wa;
        pb = !reset && (b_read || b_write) && !exp_wb;
        chk("a_waitrequest", a_waitrequest, exp_wa);
        chk("b_waitrequest", b_waitrequest, exp_wb);
        chk("mem_chipselect", mem_chipselect, pa | pb);
        chk("mem_write", mem_write, (pa & a_write) | (pb & b_write));
        if (pa | pb) chk("mem_address", mem_address, pb ? b_address : a_address);
        if (reset) exp_q.delete();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_readdatavalid", a_readdatavalid, !e.port_b);
            chk("b_readdatavalid", b_readdatavalid, e.port_b);
            chk(e.port_b ? "b_readdata" : "a_readdata", e.port_b ? b_readdata : a_readdata, e.data);
        end else begin
            chk("a_readdatavalid", a_readdatavalid, 1'b0);
            chk("b_readdatavalid", b_readdatavalid, 1'b0);
        end
        if (pa) accept(1'b0, a_write, a_address, a_writedata, a_byteenable);
        if (pb) accept(1'b1, b_write, b_address, b_writedata, b_byteenable);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] order;
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = 32'hA500_0000 | i;
            shadow[i] = 32'hA500_0000 | i;
        end
        rd_addr_q = '0;
`ifdef SOPC_ARB_BURST_EN
        order = 9'b0_1111_0000;
`else
        order = 9'b0_1010_1010;
`endif

        // Requests held during reset are not accepted.
        reset = 1'b1;
        set_a(1, 0, 12'h100, 32'h0, 4'hF);
        set_b(1, 0, 12'h200, 32'h0, 4'hF);
        cyc(1, 1);
        cyc(1, 1);
        reset = 1'b0;
        set_a(0, 0, 12'h000, 32'h0, 4'h0);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);
        cyc(0, 0);

        // A-only write then read back.
        set_a(0, 1, 12'h010, 32'hDEADBEEF, 4'hF); cyc(0, 0);
        set_a(1, 0, 12'h010, 32'h0, 4'hF);        cyc(0, 0);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);

        // Read+write together is a write; then confirm the data landed.
        set_a(1, 1, 12'h030, 32'h12345678, 4'hF); cyc(0, 0);
        set_a(1, 0, 12'h030, 32'h0, 4'hF);        cyc(0, 0);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);

        // Partial byte-enable write from A, read back by B.
        set_a(0, 1, 12'h040, 32'hFFFFFFFF, 4'b0101); cyc(0, 0);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);
        set_b(1, 0, 12'h040, 32'h0, 4'hF);           cyc(0, 0);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);           cyc(0, 0);

        // Same-address A write / B read straight after reset.
        reset = 1'b1; cyc(1, 1); reset = 1'b0;
        set_a(0, 1, 12'h020, 32'hCAFEF00D, 4'hF);
        set_b(1, 0, 12'h020, 32'h0, 4'hF);        cyc(0, 1);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);

        // Reset right after an accepted read drops its readdatavalid.
        reset = 1'b1; cyc(1, 1); reset = 1'b0;
        set_a(1, 0, 12'h010, 32'h0, 4'hF);        cyc(0, 0);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);
        reset = 1'b1; cyc(1, 1); reset = 1'b0;
        set_a(1, 0, 12'h100, 32'h0, 4'hF);
        set_b(1, 0, 12'h200, 32'h0, 4'hF);        cyc(0, 1);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);

        // Continuous contention from reset: grant order.
        reset = 1'b1; cyc(1, 1); reset = 1'b0;
        set_a(1, 0, 12'h100, 32'h0, 4'hF);
        set_b(1, 0, 12'h200, 32'h0, 4'hF);
        for (int i = 0; i < 9; i++) cyc(order[i], !order[i]);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);

        // A alone saturates its burst; the next tie must go to B.
        for (int i = 0; i < 6; i++) cyc(0, 0);
        set_b(1, 0, 12'h200, 32'h0, 4'hF);        cyc(1, 0);
        set_a(0, 0, 12'h000, 32'h0, 4'h0);
        set_b(0, 0, 12'h000, 32'h0, 4'h0);        cyc(0, 0);

        chk("mem_clken", mem_clken, 1'b1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
